// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read port plus the fetch-to-decode handoff.
interface instr_fetch_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic [PC_W-1:0]    pc_out;
    logic               instr_valid;
    modport master (
        output imem_req, imem_addr, instr, opcode, pc_out, instr_valid,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, instr, opcode, pc_out, instr_valid,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder issuing one imem read at a time and presenting the word to decode.
module instr_fetch #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            rst,
    instr_fetch_if.master  bus
);
    typedef enum logic [1:0] {S_REQ, S_VALID, S_DROP} state_t;
    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, pending_q, pending_d, pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    // pc_q is left untouched while draining in S_DROP, so it still names the in-flight address
    assign bus.imem_req    = !rst && state_q != S_VALID;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: 4];
    assign bus.pc_out      = pc_out_q;
    assign bus.instr_valid = valid_q;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        pc_out_d  = pc_out_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        case (state_q)
            S_REQ: begin
                if (bus.imem_ack && bus.redirect) begin
                    pc_d = bus.redirect_pc;
                end else if (bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + PC_W'(1);
                    valid_d  = 1'b1;
                    state_d  = S_VALID;
                end else if (bus.redirect) begin
                    pending_d = bus.redirect_pc;
                    state_d   = S_DROP;
                end
            end
            S_VALID: begin
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    pc_d    = bus.redirect_pc;
                    state_d = S_REQ;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                pending_d = bus.redirect ? bus.redirect_pc : pending_q;
                if (bus.imem_ack) begin
                    pc_d    = bus.redirect ? bus.redirect_pc : pending_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            pending_q <= '0;
            pc_out_q  <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            pc_out_q  <= pc_out_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: per-cycle directed vectors for two fetch units (reset PC 0000 and FFFF).
module tb_instr_fetch;
    typedef struct {
        logic        rst, ack;
        logic [15:0] rdata;
        logic        stall, redir;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] instr, pc_out;
    } vec_t;
    logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
    int   n_checks = 0, n_fail = 0;
    vec_t va[28];
    vec_t vb[7];
    instr_fetch_if #(.PC_W(16), .INSTR_W(16)) ifa ();
    instr_fetch_if #(.PC_W(16), .INSTR_W(16)) ifb ();
    instr_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.master));
    instr_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.master));
    always #5 clk = ~clk;
    function automatic vec_t mk(logic r, logic a, logic [15:0] d, logic s, logic rd, logic [15:0] rp,
                                logic q, logic [15:0] ad, logic v, logic [15:0] in, logic [15:0] po);
        vec_t t;
        t.rst = r; t.ack = a; t.rdata = d; t.stall = s; t.redir = rd; t.rpc = rp;
        t.req = q; t.addr = ad; t.valid = v; t.instr = in; t.pc_out = po;
        return t;
    endfunction
    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask
    task automatic apply(input bit b, input int row, input vec_t v);
        @(negedge clk);
        if (b) begin
            rst_b = v.rst; ifb.imem_ack = v.ack; ifb.imem_rdata = v.rdata;
            ifb.stall = v.stall; ifb.redirect = v.redir; ifb.redirect_pc = v.rpc;
        end else begin
            rst_a = v.rst; ifa.imem_ack = v.ack; ifa.imem_rdata = v.rdata;
            ifa.stall = v.stall; ifa.redirect = v.redir; ifa.redirect_pc = v.rpc;
        end
        #1;
        chk(b ? "b.req" : "a.req", row, {15'd0, b ? ifb.imem_req : ifa.imem_req}, {15'd0, v.req});
        chk(b ? "b.addr" : "a.addr", row, b ? ifb.imem_addr : ifa.imem_addr, v.addr);
        chk(b ? "b.valid" : "a.valid", row, {15'd0, b ? ifb.instr_valid : ifa.instr_valid}, {15'd0, v.valid});
        chk(b ? "b.instr" : "a.instr", row, b ? ifb.instr : ifa.instr, v.instr);
        chk(b ? "b.opcode" : "a.opcode", row, {12'd0, b ? ifb.opcode : ifa.opcode}, {12'd0, v.instr[15:12]});
        chk(b ? "b.pc_out" : "a.pc_out", row, b ? ifb.pc_out : ifa.pc_out, v.pc_out);
    endtask
    initial begin
        //        rst ack rdata    stl rd  rpc       req addr     vld instr    pc_out
        va[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000);
        va[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000);
        va[2]  = mk(0, 1, 16'h1234, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000);
        for (int i = 3; i < 8; i++)
            va[i] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0001, 1, 16'h1234, 16'h0000);
        va[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0001, 1, 16'h1234, 16'h0000);
        va[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0001, 0, 16'h1234, 16'h0000);
        va[10] = mk(0, 1, 16'h5ABC, 0, 0, 16'h0000,  1, 16'h0001, 0, 16'h1234, 16'h0000);
        va[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0002, 1, 16'h5ABC, 16'h0001);
        va[12] = mk(0, 1, 16'h0777, 0, 0, 16'h0000,  1, 16'h0002, 0, 16'h5ABC, 16'h0001);
        va[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0003, 1, 16'h0777, 16'h0002);
        va[14] = mk(0, 0, 16'h0000, 0, 1, 16'h0040,  1, 16'h0003, 0, 16'h0777, 16'h0002);
        va[15] = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0003, 0, 16'h0777, 16'h0002);
        va[16] = mk(0, 0, 16'h0000, 1, 0, 16'h0000,  1, 16'h0003, 0, 16'h0777, 16'h0002);
        va[17] = mk(0, 1, 16'hDEAD, 0, 0, 16'h0000,  1, 16'h0003, 0, 16'h0777, 16'h0002);
        va[18] = mk(0, 1, 16'hBEEF, 0, 1, 16'h0100,  1, 16'h0040, 0, 16'h0777, 16'h0002);
        va[19] = mk(0, 1, 16'hA111, 0, 0, 16'h0000,  1, 16'h0100, 0, 16'h0777, 16'h0002);
        va[20] = mk(0, 0, 16'h0000, 1, 1, 16'h0200,  0, 16'h0101, 1, 16'hA111, 16'h0100);
        va[21] = mk(0, 0, 16'h0000, 0, 1, 16'h0300,  1, 16'h0200, 0, 16'hA111, 16'h0100);
        va[22] = mk(0, 0, 16'h0000, 0, 1, 16'h0400,  1, 16'h0200, 0, 16'hA111, 16'h0100);
        va[23] = mk(0, 1, 16'hDEAD, 0, 0, 16'h0000,  1, 16'h0200, 0, 16'hA111, 16'h0100);
        va[24] = mk(0, 1, 16'hBEEF, 0, 1, 16'h0007,  1, 16'h0400, 0, 16'hA111, 16'h0100);
        va[25] = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0007, 0, 16'hA111, 16'h0100);
        va[26] = mk(1, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0007, 0, 16'hA111, 16'h0100);
        va[27] = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000);
        vb[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'hFFFF, 0, 16'h0000, 16'h0000);
        vb[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'hFFFF, 0, 16'h0000, 16'h0000);
        vb[2]  = mk(0, 1, 16'h1000, 0, 0, 16'h0000,  1, 16'hFFFF, 0, 16'h0000, 16'h0000);
        vb[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, 1, 16'h1000, 16'hFFFF);
        vb[4]  = mk(0, 1, 16'h2000, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h1000, 16'hFFFF);
        vb[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0001, 1, 16'h2000, 16'h0000);
        vb[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0001, 0, 16'h2000, 16'h0000);
        ifa.imem_ack = 0; ifa.imem_rdata = 0; ifa.stall = 0; ifa.redirect = 0; ifa.redirect_pc = 0;
        ifb.imem_ack = 0; ifb.imem_rdata = 0; ifb.stall = 0; ifb.redirect = 0; ifb.redirect_pc = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 28; i++) apply(1'b0, i, va[i]);
        for (int i = 0; i < 7; i++) apply(1'b1, i, vb[i]);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
